ysyx_23060278_mdu_seq: RTL



---
 rtl/ysyx_23060278_mdu_pkg.sv | 22 ++
 rtl/ysyx_23060278_mdu_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ysyx_23060278_mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// MDU ops, shared-ALU opcodes, FSM states and the datapath width.
package ysyx_23060278_mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_DIVU = 2'b01;
  localparam logic [1:0] MDU_REMU = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIVU) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/ysyx_23060278_mdu_seq.sv
// Multiply/divide sequencer driving the core's shared add/sub ALU, one
// iteration per cycle. Optional macro: YSYX_23060278_MDU_ZERO_BYPASS_EN.
module ysyx_23060278_mdu_seq
  import ysyx_23060278_mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctl,
  input  logic [XLEN-1:0] alu_result
);

`ifdef YSYX_23060278_MDU_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  // acc: product (MUL) or partial remainder (DIV/REM).
  // src: shifting multiplicand or fixed divisor.
  // shf: multiplier shifted right or dividend shifted left.
  logic [1:0]      state_reg, state_next;
  logic [1:0]      op_reg, op_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0] src_reg, src_next;
  logic [XLEN-1:0] shf_reg, shf_next;
  logic [XLEN-1:0] quo_reg, quo_next;
  logic [XLEN-1:0] result_reg, result_next;

  logic [XLEN:0]   rs;
  logic            ge;
  logic            in_zero;
  logic [XLEN-1:0] zero_result;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  assign rs       = {acc_reg, shf_reg[XLEN-1]};
  assign ge       = rs[XLEN] | (rs[XLEN-1:0] >= src_reg);
  assign rem_step = ge ? alu_result : rs[XLEN-1:0];
  assign quo_step = {quo_reg[XLEN-2:0], ge};

  assign in_zero = op_is_div(in_op) ? (in_b == '0) : ((in_a == '0) || (in_b == '0));
  assign zero_result = (in_op == MDU_DIVU) ? '1 :
                       (in_op == MDU_REMU) ? in_a : '0;

  assign in_ready   = (state_reg == ST_IDLE);
  assign out_valid  = (state_reg == ST_DONE);
  assign out_result = result_reg;

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    src_next    = src_reg;
    shf_next    = shf_reg;
    quo_next    = quo_reg;
    result_next = result_reg;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctl     = ALU_ADD;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          op_next    = in_op;
          cnt_next   = '0;
          acc_next   = '0;
          quo_next   = '0;
          src_next   = op_is_div(in_op) ? in_b : in_a;
          shf_next   = op_is_div(in_op) ? in_a : in_b;
          state_next = ST_RUN;
          if (ZERO_BYPASS && in_zero) begin
            result_next = zero_result;
            state_next  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        cnt_next = cnt_reg + 1'b1;
        if (op_is_div(op_reg)) begin
          alu_ctl  = ALU_SUB;
          alu_a    = rs[XLEN-1:0];
          alu_b    = src_reg;
          acc_next = rem_step;
          quo_next = quo_step;
          shf_next = shf_reg << 1;
        end else begin
          alu_ctl  = ALU_ADD;
          alu_a    = acc_reg;
          alu_b    = src_reg & {XLEN{shf_reg[0]}};
          acc_next = alu_result;
          src_next = src_reg << 1;
          shf_next = shf_reg >> 1;
        end
        if (cnt_reg == LAST_ITER) begin
          state_next  = ST_DONE;
          result_next = (op_reg == MDU_DIVU) ? quo_step : acc_next;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort wins over any accept or completion in the same cycle.
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      src_reg    <= '0;
      shf_reg    <= '0;
      quo_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      src_reg    <= src_next;
      shf_reg    <= shf_next;
      quo_reg    <= quo_next;
      result_reg <= result_next;
    end
  end

endmodule
